// File: rtl/activity_led_if.sv
// Activity LED bus bundle: access/error strobes in, LED drive and error flag out.
interface activity_led_if;
  logic access;
  logic err_in;
  logic err_clr;
  logic red_led;
  logic err_active;

  modport master (
    output access,
    output err_in,
    output err_clr,
    input  red_led,
    input  err_active
  );

  modport slave (
    input  access,
    input  err_in,
    input  err_clr,
    output red_led,
    output err_active
  );
endinterface

// File: rtl/activity_led.sv
// Activity LED stretcher: turns short SDRAM/Zorro access activity into
// visible flashes of at least ON_CYCLES lit followed by OFF_CYCLES dark.
// Optional error-blink mode is enabled by defining ACTIVITY_LED_ERROR_EN;
// without it err_in/err_clr are ignored and err_active is tied low.
module activity_led #(
  parameter int ON_CYCLES  = 2500000,
  parameter int OFF_CYCLES = 1250000,
  parameter int ERR_CYCLES = 12500000
) (
  input  logic           clk,
  input  logic           reset,
  activity_led_if.slave  bus
);

  localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC    = (MAX_ON_OFF > ERR_CYCLES) ? MAX_ON_OFF : ERR_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ACTIVITY_LED_ERROR_EN
  localparam logic [CNT_W-1:0] ERR_LOAD = CNT_W'(ERR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ON      = 3'd1,
    ST_OFF     = 3'd2,
    ST_ERR_ON  = 3'd3,
    ST_ERR_OFF = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             red_q, red_d;
  logic             cnt_zero_s;

  assign cnt_zero_s = (cnt_q == CNT_ZERO);

  // Next-state, counter and pending-flash logic; the counter only decrements
  // when non-zero so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.access) begin
          state_d = ST_ON;
          cnt_d   = ON_LOAD;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_ON: begin
        if (bus.access) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (cnt_zero_s) begin
          state_d = ST_OFF;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_OFF: begin
        if (cnt_zero_s) begin
          pend_d = 1'b0;
          if (pend_q || bus.access) begin
            state_d = ST_ON;
            cnt_d   = ON_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (bus.access) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end
      end
`ifdef ACTIVITY_LED_ERROR_EN
      ST_ERR_ON: begin
        if (cnt_zero_s) begin
          state_d = ST_ERR_OFF;
          cnt_d   = ERR_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_ERR_OFF: begin
        if (cnt_zero_s) begin
          state_d = ST_ERR_ON;
          cnt_d   = ERR_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        pend_d  = 1'b0;
      end
    endcase

`ifdef ACTIVITY_LED_ERROR_EN
    // A new error always (re)starts the blink at its lit phase and wins
    // over a simultaneous acknowledge.
    if (bus.err_in) begin
      state_d = ST_ERR_ON;
      cnt_d   = ERR_LOAD;
      pend_d  = 1'b0;
    end else if (bus.err_clr && (state_q == ST_ERR_ON || state_q == ST_ERR_OFF)) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      pend_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
`endif
  end

  // LED drive is decoded from the next state so it changes on the same edge
  // that samples the access.
  always_comb begin
    red_d = 1'b0;
    case (state_d)
      ST_ON:     red_d = 1'b1;
`ifdef ACTIVITY_LED_ERROR_EN
      ST_ERR_ON: red_d = 1'b1;
`endif
      default:   red_d = 1'b0;
    endcase
  end

  // State, counter, pending flag and LED output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      pend_q  <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      red_q   <= red_d;
    end
  end

  assign bus.red_led = red_q;

`ifdef ACTIVITY_LED_ERROR_EN
  logic err_act_q, err_act_d;

  // Error flag follows the next state so it rises/falls with the blink mode.
  always_comb begin
    err_act_d = 1'b0;
    if (state_d == ST_ERR_ON || state_d == ST_ERR_OFF) begin
      err_act_d = 1'b1;
    end else begin
      err_act_d = 1'b0;
    end
  end

  // Error-active output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_act_q <= 1'b0;
    end else begin
      err_act_q <= err_act_d;
    end
  end

  assign bus.err_active = err_act_q;
`else
  logic unused_err_s;
  assign unused_err_s   = bus.err_in | bus.err_clr;
  assign bus.err_active = 1'b0;
`endif

endmodule

// File: doc/activity_led.md
ACTIVITY_LED -- requirements
Module: activity_led

Interface
REQ-001 Parameter ON_CYCLES, default 2500000, minimum lit time per activity flash in clk cycles (>=1).
REQ-002 Parameter OFF_CYCLES, default 1250000, minimum dark gap after each flash in clk cycles (>=1).
REQ-003 Parameter ERR_CYCLES, default 12500000, half-period of error blink in clk cycles (>=1).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 access  input  1  level, high for each clk cycle an SDRAM/Zorro access is in progress.
REQ-007 err_in  input  1  single-cycle error strobe from the bus/SDRAM controller.
REQ-008 err_clr  input  1  single-cycle error acknowledge.
REQ-009 red_led  output  1  registered LED drive, 1 = lit; feeds the LED driver's red_led input.
REQ-010 err_active  output  1  registered, 1 while in error-blink mode.

Function
REQ-011 FSM states SHALL be IDLE, ON, OFF, ERR_ON, ERR_OFF; red_led SHALL be 1 in ON and ERR_ON, 0 otherwise.
REQ-012 IDLE: access=1 sampled at edge N SHALL enter ON with red_led=1 from edge N (one-edge latency), counter loaded ON_CYCLES-1.
REQ-013 ON: counter decrements each cycle; at 0 -> OFF, counter loaded OFF_CYCLES-1; any access=1 during ON SHALL set pending.
REQ-014 OFF: counter decrements; at 0 -> ON if pending or access=1 (pending cleared, ON_CYCLES-1 loaded), else -> IDLE; access=1 during OFF SHALL set pending.
REQ-015 Continuous access SHALL yield a square wave of exactly ON_CYCLES lit / OFF_CYCLES dark; flashes SHALL never be shorter than ON_CYCLES.
REQ-016 pending is one bit; multiple accesses within one ON/OFF window SHALL produce only one further flash.
REQ-017 Counter width SHALL be $clog2 of the largest parameter +1 and SHALL never wrap below 0.
REQ-018 ON_CYCLES=1 or OFF_CYCLES=1 SHALL give a one-cycle phase with no extra cycle.

Reset
REQ-019 reset=1 SHALL asynchronously force IDLE, counter=0, pending=0, red_led=0, err_active=0.
REQ-020 Reset asserted mid-flash or mid-error SHALL abandon the operation; after release FSM starts from IDLE only on new access/err_in.

Configuration
REQ-021 Macro ACTIVITY_LED_ERROR_EN defined: err_in=1 in any state SHALL enter ERR_ON next edge, set err_active=1, clear pending, load ERR_CYCLES-1.
REQ-022 With macro: ERR_ON/ERR_OFF alternate every ERR_CYCLES; access ignored; err_clr=1 -> IDLE next edge, err_active=0.
REQ-023 With macro: err_in and err_clr in same cycle SHALL keep/enter error mode (err_in wins); err_in while in error SHALL restart at ERR_ON.
REQ-024 Macro undefined: err_in and err_clr SHALL be ignored, ERR states not synthesised, err_active tied 0; ports remain.

Verification (ON_CYCLES=4, OFF_CYCLES=2, ERR_CYCLES=3)
REQ-025 Single access pulse at edge 10 -> red_led=1 edges 10-13, 0 from 14, IDLE at 16.
REQ-026 access held high 20 cycles from edge 0 -> red_led pattern 1111 00 1111 00 ... repeating, ends with full flash after release.
REQ-027 access pulses at edges 1 and 3 -> one flash 1-4, gap 5-6, second flash 7-10, then IDLE.
REQ-028 reset asserted at edge 2 of a flash (between edges) -> red_led=0 immediately, no resumption without new access.
REQ-029 ERROR_EN: err_in at edge 5 during ON -> err_active=1, red_led 111 000 111...; err_clr at edge 20 -> IDLE, red_led=0 at 21.
REQ-030 ERROR_EN undefined: same err_in stimulus -> err_active stays 0, red_led follows access only.
